// File: rtl/sr_frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
// Parity support is enabled by defining SR_FRAME_RX_PARITY_EN.
package sr_frame_rx_pkg;

   localparam int STATE_W = 2;
   localparam logic IDLE_LVL = 1'b1;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_PAR  = 2'd2,
      S_STOP = 2'd3
   } state_e;

   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/sr_rx_shifter.sv
// Shift-in register, MSB first, with enable and async active-low clear.
// Built for sr_frame_rx (macro SR_FRAME_RX_PARITY_EN has no effect here).
module sr_rx_shifter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;

   always_comb begin
      sreg_d = sreg_q;
      if (en_i) sreg_d = {sreg_q[WIDTH-2:0], d_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sreg_q <= '0;
      else         sreg_q <= sreg_d;
   end

   assign q_o = sreg_q;

endmodule

// File: rtl/sr_frame_rx.sv
// Serial frame receiver: start, WIDTH data bits MSB first, stop.
// Define SR_FRAME_RX_PARITY_EN to expect an even-parity bit before stop.
module sr_frame_rx
   import sr_frame_rx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             MR,
   input  logic             En,
   input  logic             Sin,
   input  logic             Ack,
   output logic [WIDTH-1:0] Q,
   output logic             Valid,
   output logic             Ferr,
   output logic             Ovr,
   output logic             Perr
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             ferr_q, ferr_d;
   logic             shift_en;
   logic             frame_ok;
   logic [WIDTH-1:0] sreg;

`ifdef SR_FRAME_RX_PARITY_EN
   logic par_q, par_d;
   logic bad_q, bad_d;
   logic perr_q, perr_d;
   assign frame_ok = !bad_q;
   assign Perr     = perr_q;
`else
   assign frame_ok = 1'b1;
   assign Perr     = 1'b0;
`endif

   sr_rx_shifter #(.WIDTH(WIDTH)) u_shift (
      .clk_i  (Clk),
      .rst_ni (MR),
      .en_i   (shift_en),
      .d_i    (Sin),
      .q_o    (sreg)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_en = 1'b0;
`ifdef SR_FRAME_RX_PARITY_EN
      par_d    = par_q;
      bad_d    = bad_q;
      perr_d   = 1'b0;
`endif
      if (En) begin
         unique case (state_q)
            S_IDLE: begin
               if (Sin != IDLE_LVL) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
`ifdef SR_FRAME_RX_PARITY_EN
                  par_d   = 1'b0;
                  bad_d   = 1'b0;
`endif
               end
            end
            S_DATA: begin
               shift_en = 1'b1;
               cnt_d    = cnt_q + 1'b1;
`ifdef SR_FRAME_RX_PARITY_EN
               par_d    = par_q ^ Sin;
`endif
               if (cnt_q == CW'(WIDTH - 1)) begin
                  cnt_d = '0;
`ifdef SR_FRAME_RX_PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_STOP;
`endif
               end
            end
`ifdef SR_FRAME_RX_PARITY_EN
            S_PAR: begin
               state_d = S_STOP;
               bad_d   = par_q ^ Sin;
               perr_d  = par_q ^ Sin;
            end
`endif
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Ack retires the held word; a completion on the same edge reloads it.
   always_comb begin
      q_d     = q_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      ferr_d  = 1'b0;
      if (valid_q && Ack) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      if (En && state_q == S_STOP) begin
         if (!Sin) begin
            ferr_d = 1'b1;
         end else if (frame_ok) begin
            if (!valid_q || Ack) begin
               q_d     = sreg;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge MR) begin
      if (!MR) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SR_FRAME_RX_PARITY_EN
         par_q   <= 1'b0;
         bad_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
`ifdef SR_FRAME_RX_PARITY_EN
         par_q   <= par_d;
         bad_q   <= bad_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign Q     = q_q;
   assign Valid = valid_q;
   assign Ovr   = ovr_q;
   assign Ferr  = ferr_q;

endmodule

// File: doc/sr_frame_rx.md
Name: sr_frame_rx

Overview:
- Serial frame receiver. The receiving end of the serial link driven by a universal shift-register transmitter, which parallel-loads a word and then shifts it out.
- Recovers start bit, WIDTH data bits (MSB first), optional parity and stop bit, then presents the word in parallel with a valid/ack handshake.
- Sits between the serial line pin and local parallel logic, in the same clock domain as the transmitter's bit strobe.

Parameters:
- WIDTH, 4, data bits per frame (2..16).

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- MR  in  1  asynchronous active-low master reset.
- En  in  1  bit strobe; Sin is sampled only on Clk edges with En=1.
- Sin  in  1  serial line; idle level 1.
- Q  out  WIDTH  last received good word.
- Valid  out  1  Q holds an unacknowledged word.
- Ack  in  1  consumer accepts Q; effective only while Valid=1.
- Ferr  out  1  one-cycle pulse: stop bit sampled as 0.
- Ovr  out  1  sticky overrun flag.
- Perr  out  1  one-cycle pulse: parity mismatch. Tied 0 when parity is disabled.

Behaviour:
- Reset: the only reset is MR, asynchronous and active-low; Clk is the single clock. MR=0 forces Q=0, Valid=0, Ferr=0, Ovr=0, Perr=0, state=IDLE, bit counter=0 and shift register=0 immediately, including mid-frame. The first frame is recognised at the first En edge with Sin=0 after MR rises.
- En=0 edges: state, counter and shift register hold. Handshake logic (Ack) still acts on every Clk edge. Ferr and Perr clear to 0 on every edge where they are not being set.
- States: IDLE, DATA, PAR (only when the parity macro is defined), STOP. Encoded 2 bits.
- IDLE: an En edge with Sin=0 is the start bit → DATA, cnt=0. An En edge with Sin=1 stays in IDLE.
- DATA: each En edge does sreg <= {sreg[WIDTH-2:0], Sin} and cnt <= cnt+1. On the edge with cnt==WIDTH-1 → PAR if enabled, else STOP. cnt is $clog2(WIDTH) bits and wraps to 0 on leaving DATA.
- STOP: next En edge → IDLE.
  - Sin=1 and frame good (no parity error):
    - Valid=0, or Valid=1 with Ack=1 on the same edge: Q<=sreg, Valid<=1.
    - Valid=1 and Ack=0: word dropped, Q unchanged, Ovr<=1.
  - Sin=0: Ferr pulses one cycle; Q and Valid unchanged.
- Latency: Q and Valid update on the Clk edge that samples the stop bit.
- Handshake: Valid=1 and Ack=1 on an edge with no simultaneous completion → Valid<=0 and Ovr<=0. Ack while Valid=0 is ignored. If a completion coincides with Ack, Q loads, Valid stays 1 and Ovr clears.
- A stop bit of 0 does not suppress start detection; the next En edge with Sin=0 starts a new frame.

Optional Feature:
- Macro SR_FRAME_RX_PARITY_EN.
- Defined:
  - PAR state follows DATA; one En edge samples the parity bit, even parity over data bits plus parity bit.
  - Mismatch: Perr pulses one cycle on that edge and the frame is flagged bad. STOP is still consumed, but the word is never loaded, Valid is unchanged and no Ovr is raised. Ferr still reports a bad stop bit.
- Undefined: no PAR state; DATA → STOP directly; Perr constant 0.

Decomposition:
- Package sr_frame_rx_pkg: state typedef (IDLE/DATA/PAR/STOP), state width constant, idle-line level constant, and a function computing counter width from WIDTH.
- Sub-module sr_rx_shifter: WIDTH-bit shift-in register with enable and async active-low clear. The top level holds the FSM, counter, parity accumulator and handshake.

Test Plan (WIDTH=4, En=1 unless stated):
- Basic frame: Sin 0,1,0,1,1,1 (start, data 1011, stop) → after stop edge Q=4'hB, Valid=1; Ack=1 one cycle → Valid=0 next edge, Q stays 4'hB.
- Reset mid-frame: MR=0 after 2 data bits → all outputs 0 immediately. After release, a full frame for 4'h6 → Q=4'h6, Valid=1; no residue from the aborted frame.
- Framing error: start, 1100, stop=0 → Ferr high exactly one cycle, Valid=0, Q=0. Immediate next frame for 4'h3 is received correctly.
- Overrun: frames 4'hA then 4'h5, no Ack → Q=4'hA, Valid=1, Ovr=1. Ack → Valid=0, Ovr=0. Also frame completion with Ack on the same edge → Q=new word, Valid=1, Ovr=0.
- En gating: frame for 4'hB with En high one cycle in three, Sin changing only between strobes → identical result to the basic frame, Valid after the stop strobe edge.
- Parity (macro defined): data 4'hB with parity 1 and stop 1 → Q=4'hB, Valid=1. Data 4'hB with parity 0 → Perr one-cycle pulse, Valid unchanged, Q unchanged.
